// File: rtl/matmul_sequencer.sv
// Memory-port sequencer computing C = A x B for square NxN unsigned matrices:
// word reads of A and B, internal multiply-accumulate, one write per C element.
module matmul_sequencer #(
  parameter int              N      = 3,
  parameter int              DATA_W = 32,
  parameter int              ADDR_W = 17,
  parameter logic [ADDR_W-1:0] A_BASE = 17'h00200,
  parameter logic [ADDR_W-1:0] B_BASE = 17'h00300,
  parameter logic [ADDR_W-1:0] C_BASE = 17'h00100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              memread,
  output logic              memwrite,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int              IW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0]   LAST = IW'(N - 1);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR, DONE} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       i_q, i_d, j_q, j_d, k_q, k_d;
  logic [DATA_W-1:0]   acc_q, acc_d, a_reg_q, a_reg_d;
  logic                overflow_q, overflow_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                memread_q, memread_d, memwrite_q, memwrite_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W:0]     mac_res;

  // Returns {overflow, truncated sum}: overflow covers both a wide product and a sum carry.
  function automatic logic [DATA_W:0] mac(input logic [DATA_W-1:0] acc,
                                          input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] b);
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W:0]     sum;
    prod = (2*DATA_W)'(a) * (2*DATA_W)'(b);
    sum  = {1'b0, acc} + {1'b0, prod[DATA_W-1:0]};
    return {(|prod[2*DATA_W-1:DATA_W]) | sum[DATA_W], sum[DATA_W-1:0]};
  endfunction

  function automatic logic [ADDR_W-1:0] elem_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [IW-1:0]     row,
                                                  input logic [IW-1:0]     col);
    logic [ADDR_W-1:0] idx;
    idx = ADDR_W'(row) * ADDR_W'(N) + ADDR_W'(col);
    return base + (idx << 2);
  endfunction

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    acc_d      = acc_q;
    a_reg_d    = a_reg_q;
    overflow_d = overflow_q;
    mac_res    = mac(acc_q, a_reg_q, mem_rdata);

    case (state_q)
      IDLE: begin
        if (start) begin
          i_d        = '0;
          j_d        = '0;
          k_d        = '0;
          acc_d      = '0;
          overflow_d = 1'b0;
          state_d    = RD_A;
        end
      end
      RD_A: begin
        a_reg_d = mem_rdata;
        state_d = RD_B;
      end
      RD_B: begin
        acc_d      = mac_res[DATA_W-1:0];
        overflow_d = overflow_q | mac_res[DATA_W];
        if (k_q != LAST) begin
          k_d     = k_q + 1'b1;
          state_d = RD_A;
        end else begin
          k_d     = '0;
          state_d = WR;
        end
      end
      WR: begin
        acc_d = '0;
        if (j_q == LAST) begin
          j_d = '0;
          i_d = (i_q == LAST) ? '0 : i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
        state_d = (i_q == LAST && j_q == LAST) ? DONE : RD_A;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are precomputed from the next state so they appear registered in that state.
    busy_d      = (state_d == RD_A) || (state_d == RD_B) || (state_d == WR);
    done_d      = (state_d == DONE);
    memread_d   = (state_d == RD_A) || (state_d == RD_B);
    memwrite_d  = (state_d == WR);
    mem_wdata_d = (state_d == WR) ? acc_d : '0;
    case (state_d)
      RD_A:    address_d = elem_addr(A_BASE, i_d, k_d);
      RD_B:    address_d = elem_addr(B_BASE, k_d, j_d);
      WR:      address_d = elem_addr(C_BASE, i_d, j_d);
      default: address_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      a_reg_q     <= '0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      memread_q   <= 1'b0;
      memwrite_q  <= 1'b0;
      address_q   <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      a_reg_q     <= a_reg_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      memread_q   <= memread_d;
      memwrite_q  <= memwrite_d;
      address_q   <= address_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = overflow_q;
  assign memread   = memread_q;
  assign memwrite  = memwrite_q;
  assign address   = address_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench for matmul_sequencer: a combinational memory model, expected
// writes/reads queued by the stimulus and popped by an independent monitor.
module tb_matmul_sequencer;
  localparam int AW = 17;
  localparam int DW = 32;

  typedef logic [31:0] mat_t [9];
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset, start;
  logic          busy, done, overflow, memread, memwrite;
  logic [AW-1:0] address;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [31:0]   mem [0:32767];
  wr_t           exp_wr [$];
  logic [AW-1:0] exp_rd [$];
  wr_t           got_wr;
  logic [AW-1:0] want_rd;
  int            checks = 0;
  int            errors = 0;
  int            done_cnt = 0;

  matmul_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .overflow(overflow), .memread(memread), .memwrite(memwrite),
    .address(address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[address[16:2]];
  always @(posedge clk) if (memwrite) mem[address[16:2]] <= mem_wdata;

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (memread && memwrite) begin
      errors++;
      $display("FAIL strobes: memread=%0b memwrite=%0b, required not both high", memread, memwrite);
    end
    if (memwrite) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%h data=%h, required no write", address, mem_wdata);
      end else begin
        got_wr = exp_wr.pop_front();
        if (address !== got_wr.addr || mem_wdata !== got_wr.data) begin
          errors++;
          $display("FAIL c_write: got addr=%h data=%h, required addr=%h data=%h",
                   address, mem_wdata, got_wr.addr, got_wr.data);
        end
      end
    end
    if (memread && exp_rd.size() > 0) begin
      want_rd = exp_rd.pop_front();
      checks++;
      if (address !== want_rd) begin
        errors++;
        $display("FAIL rd_trace: got addr=%h, required %h", address, want_rd);
      end
    end
    if (done) done_cnt++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic load(input mat_t a, input mat_t b);
    for (int e = 0; e < 9; e++) begin
      mem[(17'h200 >> 2) + e] = a[e];
      mem[(17'h300 >> 2) + e] = b[e];
    end
  endtask

  task automatic push_exp(input mat_t c);
    for (int e = 0; e < 9; e++) exp_wr.push_back({AW'(17'h100 + 4 * e), c[e]});
  endtask

  // One full run; repulse re-asserts start in cycle 10 and in the DONE cycle.
  task automatic go(input mat_t c, input bit repulse);
    int lat;
    lat = -1;
    push_exp(c);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("ovf_cleared_on_start", {31'b0, overflow}, 32'd0);
    for (int n = 2; n <= 200; n++) begin
      @(posedge clk); #1;
      if (repulse) start = (n == 10);
      if (done) begin
        lat = n;
        if (repulse) start = 1'b1;
        break;
      end
    end
    @(posedge clk); #1 start = 1'b0;
    check("done_latency", 32'(lat), 32'd64);
    check("writes_outstanding", 32'(exp_wr.size()), 32'd0);
  endtask

  mat_t a_seq, b_id, b_seq, c_seq, a_ff, b_two, c_ff;
  int   dc;

  initial begin
    a_seq = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    b_seq = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    b_id  = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    c_seq = '{30, 36, 42, 66, 81, 96, 102, 126, 150};
    a_ff  = '{default: 32'hFFFF_FFFF};
    b_two = '{default: 32'd2};
    c_ff  = '{default: 32'hFFFF_FFFA};

    // Reset state, with start asserted alongside reset.
    reset = 1'b1;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_overflow", {31'b0, overflow}, 0);
    check("rst_memread", {31'b0, memread}, 0);
    check("rst_memwrite", {31'b0, memwrite}, 0);
    check("rst_address", 32'(address), 0);
    check("rst_wdata", mem_wdata, 0);
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("idle_after_reset", {31'b0, busy}, 0);

    // Identity B with first-element read trace.
    load(a_seq, b_id);
    exp_rd.push_back(17'h200); exp_rd.push_back(17'h300);
    exp_rd.push_back(17'h204); exp_rd.push_back(17'h30C);
    exp_rd.push_back(17'h208); exp_rd.push_back(17'h318);
    go(a_seq, 1'b0);
    check("identity_ovf", {31'b0, overflow}, 0);
    check("trace_consumed", 32'(exp_rd.size()), 0);

    // A x A with ignored start pulses mid-run and in DONE.
    load(a_seq, b_seq);
    dc = done_cnt;
    go(c_seq, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("repulse_idle", {31'b0, busy}, 0);
    check("repulse_done_count", 32'(done_cnt - dc), 1);

    // Reset in cycle 20 of a run, then a fresh run.
    push_exp(c_seq);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", {31'b0, busy}, 0);
    check("midrst_memread", {31'b0, memread}, 0);
    check("midrst_memwrite", {31'b0, memwrite}, 0);
    check("midrst_address", 32'(address), 0);
    check("midrst_writes_done", 32'(exp_wr.size()), 7);
    exp_wr.delete();
    reset = 1'b0;
    go(c_seq, 1'b0);

    // Overflow: all-ones times two.
    load(a_ff, b_two);
    go(c_ff, 1'b0);
    check("ovf_set", {31'b0, overflow}, 1);
    repeat (3) @(posedge clk);
    #1 check("ovf_sticky", {31'b0, overflow}, 1);

    // Next start clears overflow (checked inside go).
    load(a_seq, b_id);
    go(a_seq, 1'b0);
    check("ovf_after_clean_run", {31'b0, overflow}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
- Controller that sequences the main data memory to compute C = A x B for square NxN unsigned 32-bit matrices.
- Sits between the top-level start/status logic and the memory port (memread, memwrite, address, data_in, data_out).
- Issues word reads of A and B, multiply-accumulates internally, and writes each C element back to the C region.
- The memory read path is combinational: read data is valid in the same cycle as the address.

Parameters:
- N, 3, matrix dimension; legal 1..8.
- DATA_W, 32, element width.
- ADDR_W, 17, memory byte-address width.
- A_BASE, 17'h00200, byte base address of matrix A (row-major, 4-byte stride).
- B_BASE, 17'h00300, byte base address of matrix B.
- C_BASE, 17'h00100, byte base address of result matrix C.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only in IDLE.
- busy  output  1  high while in RD_A, RD_B or WR.
- done  output  1  single-cycle pulse when the last C element has been written.
- overflow  output  1  sticky: some product or sum exceeded DATA_W bits in the current or last run.
- memread  output  1  memory read strobe.
- memwrite  output  1  memory write strobe.
- address  output  ADDR_W  memory byte address.
- mem_wdata  output  DATA_W  write data; drives memory data_in.
- mem_rdata  input  DATA_W  read data; from memory data_out.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset: state=IDLE; i, j, k = 0; acc = 0; a_reg = 0; busy, done, overflow, memread, memwrite = 0; address = 0; mem_wdata = 0.
- States: IDLE, RD_A, RD_B, WR, DONE.
- IDLE:
  - All strobes 0; address = 0.
  - start=1 -> clear i, j, k, acc and overflow; go to RD_A.
- RD_A:
  - memread=1; address = A_BASE + 4*(i*N+k).
  - Capture a_reg <= mem_rdata at the clock edge; go to RD_B.
- RD_B:
  - memread=1; address = B_BASE + 4*(k*N+j).
  - acc <= (acc + a_reg*mem_rdata) mod 2^DATA_W.
  - Set overflow if the full product >= 2^DATA_W or the sum carries out.
  - If k < N-1: k++ and go to RD_A. Else: k <= 0 and go to WR.
- WR:
  - memwrite=1; address = C_BASE + 4*(i*N+j); mem_wdata = acc.
  - Exactly one cycle.
  - Clear acc; advance j, wrapping j=N-1 to 0 with i++.
  - If i=N-1 and j=N-1: go to DONE. Else: go to RD_A.
- DONE: done=1 for one cycle, then go to IDLE.
- memread and memwrite are never high together. Outside RD_A/RD_B/WR both are 0 and address is 0.
- All outputs decode from registered state and counters only; no combinational path from mem_rdata or start to any output.
- Latency: start accepted at edge T0.
  - First RD_A cycle is T0+1.
  - Each C element takes 2N+1 cycles.
  - done is high in cycle T0 + N*N*(2N+1) + 1, which is T0+64 for N=3.
- start is ignored in RD_A/RD_B/WR/DONE; no queueing. start in the same cycle as reset: reset wins.
- Reset mid-operation: returns to IDLE on the next edge with all strobes low. C words already written are left as is. A new start after reset runs a complete fresh computation.
- Arithmetic:
  - Unsigned throughout.
  - Product is formed at 2*DATA_W bits and truncated to DATA_W for accumulation.
  - The overflow flag holds until the next accepted start.
- Index arithmetic wraps only as specified. No address exceeds C_BASE+4*(N*N-1) or the equivalent A/B bound.

Test Plan:
- Identity B, A=1..9, start pulse -> nine writes of 1..9 to 0x100..0x120 in row order; done high exactly 64 cycles after start edge; overflow=0.
- First-element trace -> address sequence 0x200(rd), 0x300(rd), 0x204(rd), 0x30C(rd), 0x208(rd), 0x318(rd), 0x100(wr); memread/memwrite never both 1.
- A=1..9, B=1..9 -> C = 30,36,42,66,81,96,102,126,150.
- start re-pulsed at cycle 10 and in the DONE cycle -> ignored; exactly nine writes; one done pulse.
- reset asserted in cycle 20 of a run -> next cycle busy=0, memread=memwrite=0, address=0; a subsequent start yields a full, correct result.
- A all 0xFFFFFFFF, B all 2 -> every C word = 0xFFFFFFFA; overflow=1 after done; cleared by the next start.
